// File: rtl/flash_timer_arbiter.sv
// Round-robin arbiter sharing one FlashTimer among N_REQ requesters, with a
// per-run watchdog that forces completion when the timer never answers.
module flash_timer_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WDOG_CYCLES = 1000000,
    parameter int WDOG_W      = 20
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             timeout,
    output logic             busy,
    output logic             tmr_start,
    input  logic             tmr_done
);

    localparam int                PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [WDOG_W-1:0] wdog;

    logic              any_req;
    logic [PTR_W-1:0]  next_owner;
    logic [PTR_W:0]    cand;
    logic [N_REQ-1:0]  one_hot;

    function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
        return (v == WDOG_MAX) ? v : v + 1'b1;
    endfunction

    // Scan from the farthest candidate to the nearest so the closest requester
    // after ptr (wrapping) is the one left in next_owner.
    always_comb begin
        any_req    = 1'b0;
        next_owner = ptr;
        cand       = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (req[cand[PTR_W-1:0]]) begin
                any_req    = 1'b1;
                next_owner = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        one_hot             = '0;
        one_hot[next_owner] = 1'b1;
    end

    // wdog counts cycles since tmr_start rose: 0 during LAUNCH, then +1 per cycle.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            tmr_start <= 1'b0;
            wdog      <= '0;
            ptr       <= PTR_W'(N_REQ - 1);
            owner     <= '0;
        end else begin
            tmr_start <= 1'b0;
            done      <= '0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= LAUNCH;
                        owner     <= next_owner;
                        grant     <= one_hot;
                        busy      <= 1'b1;
                        tmr_start <= 1'b1;
                        wdog      <= '0;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                    wdog  <= sat_inc(wdog);
                end
                WAIT: begin
                    if (tmr_done) begin
                        done  <= grant;
                        state <= RELEASE;
                    end else if (wdog == WDOG_LAST) begin
                        done    <= grant;
                        timeout <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        wdog <= sat_inc(wdog);
                    end
                end
                RELEASE: begin
                    grant <= '0;
                    ptr   <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_timer_arbiter.sv
// Directed bench for flash_timer_arbiter: single run, round-robin, watchdog,
// done/watchdog race, stale tmr_done and mid-run reset.
module tb_flash_timer_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] done;
    logic       timeout;
    logic       busy;
    logic       tmr_start;
    logic       tmr_done;

    int tests = 0;
    int fails = 0;

    flash_timer_arbiter #(
        .N_REQ      (4),
        .WDOG_CYCLES(16),
        .WDOG_W     (5)
    ) dut (
        .CLK_50MHZ(clk),
        .RST      (rst_n),
        .req      (req),
        .grant    (grant),
        .done     (done),
        .timeout  (timeout),
        .busy     (busy),
        .tmr_start(tmr_start),
        .tmr_done (tmr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run with tmr_done returned promptly; starts with DUT in IDLE.
    task automatic run_cycle(input string tag, input logic [3:0] exp_grant);
        tick();
        chk({tag, "_grant"}, grant, exp_grant);
        chk({tag, "_start"}, tmr_start, 1'b1);
        tick();
        chk({tag, "_start_low"}, tmr_start, 1'b0);
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
        chk({tag, "_done"}, {done, timeout}, {exp_grant, 1'b0});
        tick();
        chk({tag, "_release"}, {grant, done, busy}, 9'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        tmr_done = 1'b0;
        tick();
        tick();
        chk("reset_outs", {grant, done, timeout, busy, tmr_start}, 11'b0);

        // Single request
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        chk("single_grant", {grant, tmr_start, busy}, {4'b0001, 1'b1, 1'b1});
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("single_wait", {grant, done, tmr_start, timeout}, {4'b0001, 4'b0000, 1'b0, 1'b0});
        end
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
        req      = 4'b0000;
        chk("single_done", {grant, done, timeout, busy}, {4'b0001, 4'b0001, 1'b0, 1'b1});
        tick();
        chk("single_release", {grant, done, busy}, 9'b0);
        tick();
        chk("single_idle", {grant, done, timeout, busy, tmr_start}, 11'b0);

        // Round-robin from a fresh reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req   = 4'b1111;
        run_cycle("rr0", 4'b0001);
        run_cycle("rr1", 4'b0010);
        run_cycle("rr2", 4'b0100);
        run_cycle("rr3", 4'b1000);
        run_cycle("rr4", 4'b0001);
        req = 4'b0001;
        run_cycle("alone", 4'b0001);

        // Race: tmr_done on the watchdog terminal cycle; owner drops req and
        // other requesters appear mid-run.
        req = 4'b1000;
        tick();
        chk("race_grant", {grant, tmr_start}, {4'b1000, 1'b1});
        req = 4'b0011;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("race_wait", {grant, done, timeout}, {4'b1000, 4'b0000, 1'b0});
        end
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
        req      = 4'b0000;
        chk("race_done", {done, timeout}, {4'b1000, 1'b0});
        tick();
        chk("race_release", {grant, done, timeout, busy}, 10'b0);

        // Watchdog expiry
        req = 4'b0100;
        tick();
        chk("wd_grant", {grant, tmr_start}, {4'b0100, 1'b1});
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("wd_wait", {done, timeout, busy}, {4'b0000, 1'b0, 1'b1});
        end
        tick();
        req = 4'b0000;
        chk("wd_timeout", {grant, done, timeout}, {4'b0100, 4'b0100, 1'b1});
        tick();
        chk("wd_release", {grant, done, timeout, busy}, 10'b0);

        // Stale tmr_done in IDLE and in LAUNCH
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
        chk("stale_idle", {grant, done, timeout, busy, tmr_start}, 11'b0);
        req = 4'b0100;
        tick();
        chk("stale_launch_grant", {grant, tmr_start}, {4'b0100, 1'b1});
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
        chk("stale_launch", {grant, done, timeout, busy, tmr_start}, {4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0});
        tick();
        tick();
        chk("abort_in_wait", {grant, done, busy}, {4'b0100, 4'b0000, 1'b1});

        // Reset in WAIT: asynchronous clear, silent afterwards, requester 0 first
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        chk("abort_async", {grant, done, timeout, busy, tmr_start}, 11'b0);
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_silent", {grant, done, timeout, busy, tmr_start}, 11'b0);
        end
        req = 4'b1111;
        tick();
        chk("abort_ptr_reset", {grant, tmr_start}, {4'b0001, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
